// File: rtl/tick_bcd_counter.sv
// Tick-driven 4-digit BCD up/down counter with run/pause/clear control
// and a multiplexed 7-segment display. Option: LEADING_ZERO_BLANK_EN.
module tick_bcd_counter #(
    parameter int SCAN_POW  = 16,
    parameter int MAX_COUNT = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_w,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        up_down,
    output logic [15:0] count_bcd,
    output logic        running,
    output logic        wrap,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED
    } state_t;

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10),
                4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b) begin
                if (r[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    localparam logic [15:0] MAX_BCD = to_bcd(MAX_COUNT);

    logic                s1, s2, prev;
    logic                tick;
    state_t              state_q, state_d;
    logic [15:0]         count_d;
    logic                wrap_d;
    logic [SCAN_POW-1:0] scan_q;
    logic [1:0]          idx_q;
    logic [3:0]          digit;
    logic                blank;
    logic [6:0]          seg_d;

    // Bring clk_w into the clk domain and keep the previous level for edge detect.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= clk_w;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign tick = s2 & ~prev;

    // Control FSM and count stepping; clear beats start_stop beats tick.
    always_comb begin
        state_d = state_q;
        count_d = count_bcd;
        wrap_d  = 1'b0;
        if (clear) begin
            state_d = IDLE;
            count_d = 16'h0000;
        end else if (start_stop) begin
            case (state_q)
                RUN:     state_d = PAUSED;
                default: state_d = RUN;
            endcase
        end else if (state_q == RUN && tick) begin
            if (up_down) begin
                if (count_bcd == MAX_BCD) begin
                    count_d = 16'h0000;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = bcd_inc(count_bcd);
                end
            end else begin
                if (count_bcd == 16'h0000) begin
                    count_d = MAX_BCD;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = bcd_dec(count_bcd);
                end
            end
        end
    end

    // State, count and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_bcd <= 16'h0000;
            wrap      <= 1'b0;
            running   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_bcd <= count_d;
            wrap      <= wrap_d;
            running   <= (state_d == RUN);
        end
    end

    // Select the digit for the current scan slot and decide whether to blank it.
    always_comb begin
        digit = count_bcd[{idx_q, 2'b00} +: 4];
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        case (idx_q)
            2'd3:    blank = (count_bcd[15:12] == 4'd0);
            2'd2:    blank = (count_bcd[15:8] == 8'd0);
            2'd1:    blank = (count_bcd[15:4] == 12'd0);
            default: blank = 1'b0;
        endcase
`endif
        seg_d = blank ? 7'b1111111 : decode(digit);
    end

    // Free-running scan counter, digit index and registered display outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_q <= '0;
            idx_q  <= 2'd0;
            seg    <= 7'b1111111;
            an     <= 4'b1111;
        end else begin
            scan_q <= scan_q + 1'b1;
            if (&scan_q) begin
                idx_q <= idx_q + 2'd1;
            end
            an  <= ~(4'b0001 << idx_q);
            seg <= seg_d;
        end
    end

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Directed bench for tick_bcd_counter: one instance with MAX_COUNT=12,
// one with the default limit, both with SCAN_POW=2 and shared stimulus.
module tb_tick_bcd_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_w = 1'b0;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic        up_down = 1'b1;

    logic [15:0] count_a, count_b;
    logic        running_a, running_b;
    logic        wrap_a, wrap_b;
    logic [6:0]  seg_a, seg_b;
    logic [3:0]  an_a, an_b;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    // Edges since reset release; drives the expected scan position.
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    tick_bcd_counter #(.SCAN_POW(2), .MAX_COUNT(12)) dut_a (
        .clk(clk), .reset(reset), .clk_w(clk_w),
        .start_stop(start_stop), .clear(clear), .up_down(up_down),
        .count_bcd(count_a), .running(running_a), .wrap(wrap_a),
        .seg(seg_a), .an(an_a)
    );

    tick_bcd_counter #(.SCAN_POW(2)) dut_b (
        .clk(clk), .reset(reset), .clk_w(clk_w),
        .start_stop(start_stop), .clear(clear), .up_down(up_down),
        .count_bcd(count_b), .running(running_b), .wrap(wrap_b),
        .seg(seg_b), .an(an_b)
    );

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wpulse(input int n = 1);
        for (int i = 0; i < n; i++) begin
            clk_w = 1'b1;
            step(3);
            clk_w = 1'b0;
            step(3);
        end
    endtask

    task automatic pulse_start();
        start_stop = 1'b1;
        step();
        start_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    function automatic logic [6:0] exp_seg(input logic [15:0] c, input int i);
        logic [6:0] tbl [10];
        logic [3:0] d;
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000};
        d = c[i*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        if (i > 0 && (c >> (i * 4)) == 16'h0) return 7'b1111111;
`endif
        return tbl[d];
    endfunction

    function automatic int scan_idx();
        return ((cyc - 1) / 4) % 4;
    endfunction

    task automatic check_scan(input string tag, input logic [15:0] c,
                              input int n);
        for (int k = 0; k < n; k++) begin
            step();
            check({tag, "_an"}, {12'h0, an_b}, {12'h0, ~(4'b0001 << scan_idx())});
            check({tag, "_seg"}, {9'h0, seg_b}, {9'h0, exp_seg(c, scan_idx())});
        end
    endtask

    initial begin
        step(3);
        check("rst_count_a", count_a, 16'h0000);
        check("rst_count_b", count_b, 16'h0000);
        check("rst_running", {15'h0, running_a}, 16'h0);
        check("rst_wrap", {15'h0, wrap_a}, 16'h0);
        check("rst_seg", {9'h0, seg_a}, {9'h0, 7'b1111111});
        check("rst_an", {12'h0, an_a}, 16'h000f);
        reset = 1'b0;

        step();
        check("first_an", {12'h0, an_a}, 16'h000e);
        check("first_seg", {9'h0, seg_a}, {9'h0, 7'b1000000});
        check_scan("scan0", 16'h0000, 15);
        check("idle_running", {15'h0, running_b}, 16'h0);
        check("idle_wrap", {15'h0, wrap_b}, 16'h0);

        pulse_start();
        check("start_running", {15'h0, running_a}, 16'h1);
        clk_w = 1'b1;
        step(2);
        check("lat_edge2", count_a, 16'h0000);
        step();
        check("lat_edge3", count_a, 16'h0001);
        step(50);
        check("hold_high", count_a, 16'h0001);
        clk_w = 1'b0;
        step(3);

        wpulse(8);
        check("up_0009", count_a, 16'h0009);
        wpulse(1);
        check("carry_0010", count_a, 16'h0010);
        wpulse(2);
        check("up_max12", count_a, 16'h0012);
        check("up_max12_wrap", {15'h0, wrap_a}, 16'h0);
        clk_w = 1'b1;
        step(3);
        check("wrap12_count", count_a, 16'h0000);
        check("wrap12_pulse", {15'h0, wrap_a}, 16'h1);
        check("nowrap_b", count_b, 16'h0013);
        step();
        check("wrap12_end", {15'h0, wrap_a}, 16'h0);
        clk_w = 1'b0;
        step(2);

        wpulse(86);
        check("up_0099", count_b, 16'h0099);
        wpulse(1);
        check("carry_0100", count_b, 16'h0100);
        check("wrap12_mod", count_a, 16'h0009);

        pulse_clear();
        check("clr_count", count_b, 16'h0000);
        check("clr_running", {15'h0, running_b}, 16'h0);
        pulse_start();
        up_down = 1'b0;
        clk_w = 1'b1;
        step(3);
        check("down_wrap_b", count_b, 16'h9999);
        check("down_wrap_b_w", {15'h0, wrap_b}, 16'h1);
        check("down_wrap_a", count_a, 16'h0012);
        clk_w = 1'b0;
        step(3);
        clk_w = 1'b1;
        step(3);
        check("down_9998", count_b, 16'h9998);
        check("down_9998_w", {15'h0, wrap_b}, 16'h0);
        check("down_0011", count_a, 16'h0011);
        clk_w = 1'b0;
        step(3);

        pulse_clear();
        pulse_start();
        up_down = 1'b1;
        wpulse(42);
        check("at_0042", count_b, 16'h0042);
        clk_w = 1'b1;
        step(2);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_tick_cnt", count_b, 16'h0000);
        check("clr_tick_run", {15'h0, running_b}, 16'h0);
        check("clr_tick_wrap", {15'h0, wrap_b}, 16'h0);
        clk_w = 1'b0;
        step(3);
        wpulse(1);
        check("idle_no_step", count_b, 16'h0000);

        pulse_start();
        wpulse(1);
        check("run_0001", count_b, 16'h0001);
        clk_w = 1'b1;
        step(2);
        start_stop = 1'b1;
        step();
        start_stop = 1'b0;
        check("ss_tick_cnt", count_b, 16'h0001);
        check("ss_tick_run", {15'h0, running_b}, 16'h0);
        clk_w = 1'b0;
        step(3);
        wpulse(2);
        check("paused_hold", count_b, 16'h0001);
        clk_w = 1'b1;
        step(2);
        start_stop = 1'b1;
        step();
        start_stop = 1'b0;
        check("resume_cnt", count_b, 16'h0001);
        check("resume_run", {15'h0, running_b}, 16'h1);
        clk_w = 1'b0;
        step(3);
        wpulse(1);
        check("resume_step", count_b, 16'h0002);

        wpulse(38);
        check("at_0040", count_b, 16'h0040);
        check("at_0040_a", count_a, 16'h0001);
        check_scan("scan40", 16'h0040, 16);

        pulse_clear();
        pulse_start();
        wpulse(37);
        check("at_0037", count_b, 16'h0037);
        reset = 1'b1;
        step();
        check("mid_rst_cnt", count_b, 16'h0000);
        check("mid_rst_run", {15'h0, running_b}, 16'h0);
        check("mid_rst_wrap", {15'h0, wrap_b}, 16'h0);
        check("mid_rst_seg", {9'h0, seg_b}, {9'h0, 7'b1111111});
        check("mid_rst_an", {12'h0, an_b}, 16'h000f);
        reset = 1'b0;
        step();
        check("post_rst_an", {12'h0, an_b}, 16'h000e);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
